// File: rtl/gen_yield_sequencer.sv
// Output stage for generator functions: latches a block of signed values on _start and
// emits them as NUM_YIELDS yields of NUM_OUTS values each over a valid/ready handshake.
module gen_yield_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_OUTS   = 2,
  parameter int unsigned NUM_YIELDS = 2,
  parameter int unsigned LOOP       = 0,
  localparam int unsigned IW = (NUM_YIELDS > 1) ? $clog2(NUM_YIELDS) : 1,
  localparam int unsigned YW = NUM_OUTS * WIDTH
) (
  input  logic                       _clock,
  input  logic                       _reset,
  input  logic                       _start,
  input  logic [NUM_YIELDS*YW-1:0]   _in,
  input  logic                       _ready,
  output logic [YW-1:0]              _out,
  output logic                       _valid,
  output logic [IW-1:0]              _index,
  output logic                       _done
);

  typedef enum logic [1:0] {StIdle, StEmit, StDone} state_e;

  state_e                   state_q;
  logic [NUM_YIELDS*YW-1:0] data_q;
  logic [IW:0]              nxt_idx;
  logic                     last;
  logic [YW-1:0]            nxt_yield;

  assign nxt_idx = {1'b0, _index} + (IW+1)'(1);
  assign last    = (_index == IW'(NUM_YIELDS - 1));

  // Yield following the current one; only consulted when the current yield is not the last.
  always_comb begin
    nxt_yield = data_q[YW-1:0];
    for (int unsigned y = 1; y < NUM_YIELDS; y++) begin
      if (nxt_idx == (IW+1)'(y)) nxt_yield = data_q[y*YW +: YW];
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      _out    <= '0;
      _valid  <= 1'b0;
      _index  <= '0;
      _done   <= 1'b0;
    end else if (_start) begin
      // Start wins over any handshake in the same cycle, including a mid-run abort.
      state_q <= StEmit;
      data_q  <= _in;
      _out    <= _in[YW-1:0];
      _valid  <= 1'b1;
      _index  <= '0;
      _done   <= 1'b0;
    end else begin
      case (state_q)
        StEmit: begin
          if (_ready) begin
            if (!last) begin
              _out   <= nxt_yield;
              _index <= nxt_idx[IW-1:0];
            end else if (LOOP != 0) begin
              _out   <= data_q[YW-1:0];
              _index <= '0;
            end else begin
              state_q <= StDone;
              _valid  <= 1'b0;
              _done   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_yield_sequencer.sv
// Bench for gen_yield_sequencer: three configurations checked every cycle against a
// queue-free yield-pointer model, plus directed scenarios with literal expectations.
module tb_gen_yield_sequencer;

  localparam int NO_T [3] = '{2, 3, 2};
  localparam int NY_T [3] = '{2, 3, 2};
  localparam int LP_T [3] = '{0, 0, 1};

  logic         clock = 1'b0;
  logic         rst;
  logic [2:0]   start, ready, valid, done;
  logic [127:0] in0, in2;
  logic [71:0]  in1;
  logic [63:0]  out0, out2;
  logic [23:0]  out1;
  logic         idx0, idx2;
  logic [1:0]   idx1;

  int cur_in  [3][9];
  int act_out [3][3];
  int act_idx [3];

  // Model state
  int vals    [3][9];
  int ptr     [3];
  bit run     [3];
  bit fin     [3];
  int exp_out [3][3];

  int errors = 0;
  int checks = 0;
  int hs0 = 0;
  int hs_base;

  always #5 clock = ~clock;

  gen_yield_sequencer dut0 (
    ._clock(clock), ._reset(rst), ._start(start[0]), ._in(in0), ._ready(ready[0]),
    ._out(out0), ._valid(valid[0]), ._index(idx0), ._done(done[0])
  );

  gen_yield_sequencer #(.WIDTH(8), .NUM_OUTS(3), .NUM_YIELDS(3), .LOOP(0)) dut1 (
    ._clock(clock), ._reset(rst), ._start(start[1]), ._in(in1), ._ready(ready[1]),
    ._out(out1), ._valid(valid[1]), ._index(idx1), ._done(done[1])
  );

  gen_yield_sequencer #(.WIDTH(32), .NUM_OUTS(2), .NUM_YIELDS(2), .LOOP(1)) dut2 (
    ._clock(clock), ._reset(rst), ._start(start[2]), ._in(in2), ._ready(ready[2]),
    ._out(out2), ._valid(valid[2]), ._index(idx2), ._done(done[2])
  );

  always_comb begin
    in0 = '0;
    in1 = '0;
    in2 = '0;
    for (int k = 0; k < 4; k++) begin
      in0[k*32 +: 32] = cur_in[0][k];
      in2[k*32 +: 32] = cur_in[2][k];
    end
    for (int k = 0; k < 9; k++) in1[k*8 +: 8] = cur_in[1][k][7:0];
  end

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      act_out[0][j] = 0;
      act_out[2][j] = 0;
      act_out[1][j] = int'($signed(out1[j*8 +: 8]));
    end
    for (int j = 0; j < 2; j++) begin
      act_out[0][j] = $signed(out0[j*32 +: 32]);
      act_out[2][j] = $signed(out2[j*32 +: 32]);
    end
    act_idx[0] = int'(idx0);
    act_idx[1] = int'(idx1);
    act_idx[2] = int'(idx2);
  end

  always @(posedge clock) if (valid[0] && ready[0]) hs0 <= hs0 + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset(int g);
    run[g] = 1'b0;
    fin[g] = 1'b0;
    ptr[g] = 0;
    for (int j = 0; j < 3; j++) exp_out[g][j] = 0;
  endtask

  task automatic show(int g);
    for (int j = 0; j < NO_T[g]; j++) exp_out[g][j] = vals[g][ptr[g]*NO_T[g] + j];
  endtask

  // Yield-pointer model: start latches and shows yield 0, each accepted yield advances.
  initial forever begin
    @(posedge clock);
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        model_reset(g);
      end else if (start[g]) begin
        for (int k = 0; k < 9; k++) vals[g][k] = cur_in[g][k];
        ptr[g] = 0;
        run[g] = 1'b1;
        fin[g] = 1'b0;
        show(g);
      end else if (run[g] && ready[g]) begin
        if (ptr[g] + 1 < NY_T[g]) begin
          ptr[g]++;
          show(g);
        end else if (LP_T[g] != 0) begin
          ptr[g] = 0;
          show(g);
        end else begin
          run[g] = 1'b0;
          fin[g] = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("d%0d_valid", g), int'(valid[g]), int'(run[g]));
      chk($sformatf("d%0d_done", g), int'(done[g]), int'(fin[g]));
      chk($sformatf("d%0d_index", g), act_idx[g], ptr[g]);
      for (int j = 0; j < NO_T[g]; j++)
        chk($sformatf("d%0d_out%0d", g, j), act_out[g][j], exp_out[g][j]);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    ready = '0;
    for (int g = 0; g < 3; g++) model_reset(g);
    repeat (2) cyc();
    @(negedge clock);
    for (int g = 0; g < 3; g++) begin
      chk("reset_valid", int'(valid[g]), 0);
      chk("reset_done", int'(done[g]), 0);
      chk("reset_index", act_idx[g], 0);
      chk("reset_out0", act_out[g][0], 0);
    end
    cyc();
    rst = 1'b0;
    cyc();

    // Basic two-yield run
    for (int k = 0; k < 4; k++) cur_in[0][k] = k + 1;
    ready[0] = 1'b1;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    @(negedge clock);
    chk("basic_y0_lo", act_out[0][0], 1);
    chk("basic_y0_hi", act_out[0][1], 2);
    chk("basic_y0_idx", act_idx[0], 0);
    chk("basic_y0_valid", int'(valid[0]), 1);
    cyc();
    @(negedge clock);
    chk("basic_y1_lo", act_out[0][0], 3);
    chk("basic_y1_hi", act_out[0][1], 4);
    chk("basic_y1_idx", act_idx[0], 1);
    cyc();
    @(negedge clock);
    chk("basic_end_valid", int'(valid[0]), 0);
    chk("basic_end_done", int'(done[0]), 1);
    chk("basic_end_hi", act_out[0][1], 4);

    // Backpressure: three refused cycles before acceptance
    hs_base  = hs0;
    ready[0] = 1'b0;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("bp_hold_lo", act_out[0][0], 1);
      chk("bp_hold_hi", act_out[0][1], 2);
      cyc();
      if (i == 2) ready[0] = 1'b1;
    end
    @(negedge clock);
    chk("bp_y1_lo", act_out[0][0], 3);
    cyc();
    @(negedge clock);
    chk("bp_done", int'(done[0]), 1);
    chk("bp_handshakes", hs0 - hs_base, 2);

    // Signed 8-bit, 3x3; input changes after start must be ignored
    for (int k = 0; k < 9; k++) cur_in[1][k] = -128 + k;
    ready[1] = 1'b1;
    start[1] = 1'b1;
    cyc();
    start[1] = 1'b0;
    for (int k = 0; k < 9; k++) cur_in[1][k] = 0;
    for (int y = 0; y < 3; y++) begin
      @(negedge clock);
      chk("signed_idx", act_idx[1], y);
      for (int j = 0; j < 3; j++) chk("signed_val", act_out[1][j], -128 + y*3 + j);
      cyc();
    end
    @(negedge clock);
    chk("signed_done", int'(done[1]), 1);

    // Looping configuration
    for (int k = 0; k < 4; k++) cur_in[2][k] = k + 1;
    ready[2] = 1'b1;
    start[2] = 1'b1;
    cyc();
    start[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("loop_idx", act_idx[2], i % 2);
      chk("loop_lo", act_out[2][0], (i % 2) * 2 + 1);
      chk("loop_done", int'(done[2]), 0);
      cyc();
    end
    ready[2] = 1'b0;

    // Abort during yield 1 with new values
    for (int k = 0; k < 4; k++) cur_in[0][k] = k + 1;
    ready[0] = 1'b1;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    cyc();
    start[0] = 1'b1;
    for (int k = 0; k < 4; k++) cur_in[0][k] = (k + 1) * 10;
    @(negedge clock);
    chk("abort_pre_idx", act_idx[0], 1);
    cyc();
    start[0] = 1'b0;
    @(negedge clock);
    chk("abort_lo", act_out[0][0], 10);
    chk("abort_hi", act_out[0][1], 20);
    chk("abort_idx", act_idx[0], 0);
    chk("abort_done", int'(done[0]), 0);

    // Asynchronous reset between edges while emitting
    ready[0] = 1'b0;
    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    chk("areset_pre_valid", int'(valid[0]), 1);
    #1;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) model_reset(g);
    #1;
    chk("areset_valid", int'(valid[0]), 0);
    chk("areset_done", int'(done[0]), 0);
    chk("areset_out_lo", act_out[0][0], 0);
    chk("areset_out_hi", act_out[0][1], 0);
    cyc();
    rst = 1'b0;
    ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("areset_idle_valid", int'(valid[0]), 0);
      cyc();
    end

    // Randomised traffic on all configurations
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        for (int g = 0; g < 3; g++) model_reset(g);
      end else begin
        rst = 1'b0;
      end
      for (int g = 0; g < 3; g++) begin
        start[g] = ($urandom_range(0, 11) == 0);
        ready[g] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 9; k++)
          cur_in[g][k] = (g == 1) ? int'($urandom_range(0, 255)) - 128 : int'($urandom);
      end
      cyc();
    end
    rst   = 1'b0;
    start = '0;
    cyc();
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1);
  end

endmodule
